// File: rtl/ni_pkt_encoder.sv
// Source-side NI packetizer: encodes a destination bitmap as unicast/multicast and emits flits
// under per-VC credit flow control. Define NI_STATS_EN to add packet/drop statistic counters.
module ni_pkt_encoder #(
   parameter int unsigned MY_XPOS   = 0,
   parameter int unsigned MY_YPOS   = 0,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [19:0]       req_mask,
   input  logic [3:0]        req_len,
   input  logic              pld_valid,
   output logic              pld_ready,
   input  logic [DATA_W-1:0] pld_data,
   output logic              flit_valid,
   output logic [1:0]        flit_type,
   output logic              flit_vc,
   output logic              flit_um_type,
   output logic [4:0]        flit_addr0,
   output logic [19:0]       flit_addr1,
   output logic [DATA_W-1:0] flit_data,
   input  logic [1:0]        credit_in,
   output logic              drop_pulse
`ifdef NI_STATS_EN
   ,
   output logic [15:0]       stat_ucast,
   output logic [15:0]       stat_mcast,
   output logic [7:0]        stat_drop
`endif
);

   localparam int unsigned MyPos = MY_XPOS * 4 + MY_YPOS;
   localparam int unsigned CrW = $clog2(BUF_DEPTH + 1);
   localparam logic [CrW-1:0] CrMax = CrW'(BUF_DEPTH);
   localparam logic [CrW-1:0] CrOne = CrW'(1);

   localparam logic [1:0] FtHead     = 2'b00;
   localparam logic [1:0] FtBody     = 2'b01;
   localparam logic [1:0] FtTail     = 2'b10;
   localparam logic [1:0] FtHeadTail = 2'b11;

   typedef enum logic [1:0] {StIdle, StVcsel, StHead, StBody} state_e;

   state_e r_state, w_state_d;

   logic [19:0]            w_eff_mask;
   logic [4:0]             w_pop, w_idx;
   logic                   w_send, w_latch, w_drop, w_is_body, w_tail, w_vc_sel;
   logic [1:0]             w_type, w_dec;

   logic                   r_um, r_vc;
   logic [4:0]             r_addr0;
   logic [19:0]            r_addr1;
   logic [3:0]             r_len, r_bcnt;
   logic [1:0][CrW-1:0]    r_credit;

   logic                   r_flit_valid, r_flit_vc, r_flit_um, r_drop;
   logic [1:0]             r_flit_type;
   logic [4:0]             r_flit_addr0;
   logic [19:0]            r_flit_addr1;
   logic [DATA_W-1:0]      r_flit_data;

   // The PE never sends to itself, so its own bit is ignored.
   assign w_eff_mask = req_mask & ~(20'd1 << MyPos);

   always_comb begin
      w_pop = '0;
      w_idx = '0;
      for (int i = 0; i < 20; i++) begin
         if (w_eff_mask[i]) begin
            w_pop = w_pop + 5'd1;
            w_idx = 5'(i);
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      req_ready = 1'b0;
      pld_ready = 1'b0;
      w_send    = 1'b0;
      w_latch   = 1'b0;
      w_drop    = 1'b0;
      w_is_body = 1'b0;
      w_tail    = 1'b0;
      w_type    = FtHead;
      w_vc_sel  = r_vc;
      case (r_state)
         StIdle: begin
            req_ready = rst_n;
            if (req_valid && rst_n) begin
               if (w_pop == '0) begin
                  w_drop = 1'b1;
               end else begin
                  w_latch   = 1'b1;
                  w_state_d = StVcsel;
               end
            end
         end
         StVcsel: begin
            if (r_credit[0] != '0) begin
               w_send   = 1'b1;
               w_vc_sel = 1'b0;
            end else if (r_credit[1] != '0) begin
               w_send   = 1'b1;
               w_vc_sel = 1'b1;
            end
            if (w_send) begin
               w_tail    = (r_len == '0);
               w_type    = w_tail ? FtHeadTail : FtHead;
               w_state_d = StHead;
            end
         end
         // Head flit is on the wire this cycle; it was decided in StVcsel.
         StHead: w_state_d = (r_len == '0) ? StIdle : StBody;
         StBody: begin
            if (pld_valid && (r_credit[r_vc] != '0)) begin
               pld_ready = 1'b1;
               w_send    = 1'b1;
               w_is_body = 1'b1;
               w_tail    = (r_bcnt == r_len - 4'd1);
               w_type    = w_tail ? FtTail : FtBody;
               if (w_tail) w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign w_dec = {w_send & w_vc_sel, w_send & ~w_vc_sel};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_um         <= 1'b0;
         r_vc         <= 1'b0;
         r_addr0      <= '0;
         r_addr1      <= '0;
         r_len        <= '0;
         r_bcnt       <= '0;
         r_credit     <= {CrMax, CrMax};
         r_flit_valid <= 1'b0;
         r_flit_type  <= '0;
         r_flit_vc    <= 1'b0;
         r_flit_um    <= 1'b0;
         r_flit_addr0 <= '0;
         r_flit_addr1 <= '0;
         r_flit_data  <= '0;
         r_drop       <= 1'b0;
      end else begin
         if (w_latch) begin
            r_um    <= (w_pop > 5'd1);
            r_addr0 <= (w_pop == 5'd1) ? w_idx : '0;
            r_addr1 <= (w_pop > 5'd1) ? w_eff_mask : '0;
            r_len   <= req_len;
            r_bcnt  <= '0;
         end
         if (w_send && (r_state == StVcsel)) r_vc <= w_vc_sel;
         if (w_send && w_is_body) r_bcnt <= r_bcnt + 4'd1;
         r_flit_valid <= w_send;
         r_drop       <= w_drop;
         if (w_send) begin
            r_flit_type  <= w_type;
            r_flit_vc    <= w_vc_sel;
            r_flit_um    <= w_is_body ? 1'b0 : r_um;
            r_flit_addr0 <= w_is_body ? '0 : r_addr0;
            r_flit_addr1 <= w_is_body ? '0 : r_addr1;
            r_flit_data  <= w_is_body ? pld_data : '0;
         end
         // Same-cycle send and return cancel out; returns saturate at the buffer depth.
         for (int v = 0; v < 2; v++) begin
            case ({w_dec[v], credit_in[v]})
               2'b10:   r_credit[v] <= r_credit[v] - CrOne;
               2'b01:   if (r_credit[v] < CrMax) r_credit[v] <= r_credit[v] + CrOne;
               default: r_credit[v] <= r_credit[v];
            endcase
         end
      end
   end

   assign flit_valid   = r_flit_valid;
   assign flit_type    = r_flit_type;
   assign flit_vc      = r_flit_vc;
   assign flit_um_type = r_flit_um;
   assign flit_addr0   = r_flit_addr0;
   assign flit_addr1   = r_flit_addr1;
   assign flit_data    = r_flit_data;
   assign drop_pulse   = r_drop;

`ifdef NI_STATS_EN
   logic [15:0] r_ucast, r_mcast;
   logic [7:0]  r_ndrop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ucast <= '0;
         r_mcast <= '0;
         r_ndrop <= '0;
      end else begin
         if (w_send && w_tail && !r_um) r_ucast <= r_ucast + 16'd1;
         if (w_send && w_tail && r_um)  r_mcast <= r_mcast + 16'd1;
         if (w_drop)                    r_ndrop <= r_ndrop + 8'd1;
      end
   end

   assign stat_ucast = r_ucast;
   assign stat_mcast = r_mcast;
   assign stat_drop  = r_ndrop;
`endif

endmodule
